// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: digit-load, display-control and active-set signals
// shared between the scan scheduler and whatever drives it.
interface display_scan_ctrl_if;
    logic       load;
    logic [4:0] din0;
    logic [4:0] din1;
    logic [4:0] din2;
    logic [4:0] din3;
    logic       lz_en;
    logic [1:0] brightness;
    logic       ack;
    logic       pending;
    logic [1:0] digit;
    logic [4:0] d0;
    logic [4:0] d1;
    logic [4:0] d2;
    logic [4:0] d3;
    logic       blank;

    modport master (
        output load, din0, din1, din2, din3, lz_en, brightness,
        input  ack, pending, digit, d0, d1, d2, d3, blank
    );

    modport slave (
        input  load, din0, din1, din2, din3, lz_en, brightness,
        output ack, pending, digit, d0, d1, d2, d3, blank
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit scan scheduler with frame-synchronous double
// buffering, leading-zero suppression and duty-cycle dimming.
module display_scan_ctrl #(
    parameter int PRESCALE = 100000
) (
    input logic               clk,
    input logic               reset,
    display_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(PRESCALE);

    if (PRESCALE < 4 || PRESCALE % 4 != 0) begin : g_bad_prescale
        $error("PRESCALE must be >= 4 and a multiple of 4");
    end

    logic [CW-1:0] cnt;
    logic [1:0]    digit;
    logic [4:0]    act [4];
    logic [4:0]    pend_buf [4];
    logic          pending;
    logic          ack;
    logic          tick;
    logic          frame_end;
    logic          commit;
    logic [CW:0]   thr;
    logic          dim;
    logic [3:0]    z;

    assign tick      = cnt == CW'(PRESCALE - 1);
    assign frame_end = tick && digit == 2'd3;
    assign commit    = frame_end && pending;

    // A load on the commit edge still lands in the buffer: the old buffer
    // is what gets committed, so pending stays set for the new data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            digit    <= '0;
            act      <= '{default: '0};
            pend_buf <= '{default: '0};
            pending  <= 1'b0;
            ack      <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            digit   <= tick ? digit + 2'd1 : digit;
            ack     <= commit;
            pending <= bus.load || (pending && !frame_end);
            if (commit)
                act <= pend_buf;
            if (bus.load) begin
                pend_buf[0] <= bus.din0;
                pend_buf[1] <= bus.din1;
                pend_buf[2] <= bus.din2;
                pend_buf[3] <= bus.din3;
            end
        end
    end

    // Threshold can reach PRESCALE itself, hence one extra bit over cnt.
    assign thr = (CW+1)'(PRESCALE / 4) * ((CW+1)'(bus.brightness) + 1'b1);
    assign dim = {1'b0, cnt} >= thr;

    assign z[3] = bus.lz_en && act[3] == 5'd0;
    assign z[2] = z[3] && act[2] == 5'd0;
    assign z[1] = z[2] && act[1] == 5'd0;
    assign z[0] = 1'b0;

    assign bus.blank   = z[digit] || dim;
    assign bus.ack     = ack;
    assign bus.pending = pending;
    assign bus.digit   = digit;
    assign bus.d0      = act[0];
    assign bus.d1      = act[1];
    assign bus.d2      = act[2];
    assign bus.d3      = act[3];
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed test with a commit scoreboard; expected
// active sets are queued at load time and checked on every ack pulse.
module tb_display_scan_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [19:0] exp_q [$];

    display_scan_ctrl_if bus();

    display_scan_ctrl #(.PRESCALE(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_load(input logic [4:0] a0, a1, a2, a3, input bit commits);
        bus.din0 = a0;
        bus.din1 = a1;
        bus.din2 = a2;
        bus.din3 = a3;
        bus.load = 1'b1;
        if (commits) exp_q.push_back({a3, a2, a1, a0});
        step();
        bus.load = 1'b0;
    endtask

    // Scoreboard monitor: every ack must match the oldest expected commit.
    always @(negedge clk) begin
        if (!reset && bus.ack) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL commit at cycle %0d: unexpected ack, d3..d0=%0h", cyc,
                         {bus.d3, bus.d2, bus.d1, bus.d0});
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({bus.d3, bus.d2, bus.d1, bus.d0} !== e) begin
                    bad++;
                    $display("FAIL commit at cycle %0d: got=%0h expected=%0h", cyc,
                             {bus.d3, bus.d2, bus.d1, bus.d0}, e);
                end
            end
        end
    end

    initial begin
        bus.load = 1'b0;
        bus.din0 = '0;
        bus.din1 = '0;
        bus.din2 = '0;
        bus.din3 = '0;
        bus.lz_en = 1'b0;
        bus.brightness = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        #1;
        chk("rst_digit", bus.digit, 0);
        chk("rst_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_ack", bus.ack, 0);

        // Idle frame: digit stepping, no blanking
        for (int c = 0; c < 32; c++) begin
            chk("digit", bus.digit, (cyc / 8) % 4);
            chk("idle_blank", bus.blank, 0);
            step();
        end
        chk("digit_wrap", bus.digit, 0);
        chk("idle_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 0);

        // Single load, commits at the frame end
        goto(37);
        do_load(5'h01, 5'h02, 5'h03, 5'h04, 1'b1);
        chk("pend_set", bus.pending, 1);
        goto(63);
        chk("pend_hold", bus.pending, 1);
        chk("no_early", bus.d0, 0);
        step();
        chk("pend_clr", bus.pending, 0);
        chk("commit_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 20'h20c41);

        // Two loads in one frame: last write wins
        goto(66);
        do_load(5'h0a, 5'h0b, 5'h0c, 5'h0d, 1'b0);
        goto(74);
        do_load(5'h11, 5'h12, 5'h13, 5'h14, 1'b1);
        goto(96);
        chk("lww_d0", bus.d0, 5'h11);
        chk("lww_pend", bus.pending, 0);

        // Load on the frame-end cycle while pending
        goto(116);
        do_load(5'h05, 5'h06, 5'h07, 5'h08, 1'b1);
        goto(127);
        do_load(5'h15, 5'h16, 5'h17, 5'h18, 1'b1);
        chk("coll_pend", bus.pending, 1);
        chk("coll_d0", bus.d0, 5'h05);
        goto(160);
        chk("coll2_d0", bus.d0, 5'h15);
        chk("coll2_pend", bus.pending, 0);

        // Leading-zero suppression
        goto(161);
        do_load(5'h00, 5'h07, 5'h00, 5'h00, 1'b1);
        goto(192);
        bus.lz_en = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            goto(192 + 8 * k + 3);
            chk("lz_blank", bus.blank, k >= 2);
        end
        goto(220);
        do_load(5'h00, 5'h07, 5'h10, 5'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            goto(224 + 8 * k + 3);
            chk("lz_dp_blank", bus.blank, k == 3);
        end

        // Dimming by brightness
        goto(256);
        bus.lz_en = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.brightness = 2'(b);
            #1;
            for (int i = 0; i < 8; i++) begin
                chk("dim_blank", bus.blank, i >= 2 * (b + 1));
                step();
            end
        end
        bus.brightness = 2'd3;

        // Reset mid-slot with pending data
        goto(281);
        do_load(5'h1f, 5'h1e, 5'h1d, 5'h1c, 1'b0);
        chk("pre_rst_pend", bus.pending, 1);
        goto(285);
        reset = 1'b1;
        #1;
        chk("arst_digit", bus.digit, 0);
        chk("arst_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 0);
        chk("arst_pending", bus.pending, 0);
        chk("arst_ack", bus.ack, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        bus.lz_en = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            goto(8 * k + 3);
            chk("post_rst_digit", bus.digit, k);
            chk("post_rst_blank", bus.blank, k != 0);
        end
        goto(40);
        chk("post_rst_pend", bus.pending, 0);
        chk("post_rst_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Scan scheduler for the 4-digit seven-segment decoder.
- It time-multiplexes the shared segment/anode datapath by stepping the 2-bit digit select at a fixed refresh rate.
- It double-buffers the four 5-bit digit codes ({dp, hex}) so updates are committed only on frame boundaries (no tearing).
- It generates a blank strobe for leading-zero suppression and brightness dimming; the top level forces all anodes off while blank=1.

Parameters:
- PRESCALE, 100000, clk cycles per digit slot (1 ms at 100 MHz). Must be >= 4 and divisible by 4.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- load  in  1  single-cycle request to capture din0..din3
- din0  in  5  new digit 0 code {dp, hex}
- din1  in  5  new digit 1 code
- din2  in  5  new digit 2 code
- din3  in  5  new digit 3 code
- lz_en  in  1  leading-zero suppression enable
- brightness  in  2  duty select; on-time = (brightness+1)/4 of each slot
- ack  out  1  one-cycle pulse when pending data is committed to the active set
- pending  out  1  captured data is awaiting commit
- digit  out  2  current digit select to the decoder
- d0  out  5  active digit 0 code
- d1  out  5  active digit 1 code
- d2  out  5  active digit 2 code
- d3  out  5  active digit 3 code
- blank  out  1  1 = all anodes off for the current cycle

Behaviour:
- Reset (async, active-high): cnt=0, digit=0, active d0..d3=0, pending buffer=0, pending=0, ack=0. Reset mid-frame discards pending data and does not assert ack.
- Prescaler:
  - cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick = (cnt==PRESCALE-1).
  - On tick, digit increments modulo 4 (3 -> 0).
  - frame_end = tick && digit==3.
- Capture:
  - On a cycle with load=1, din0..din3 are registered into the pending buffer and pending<=1.
  - Repeated loads before a commit overwrite the buffer (last write wins); no error is flagged.
- Commit:
  - On frame_end with pending=1 (registered value at that edge): active<=pending buffer, ack<=1 for exactly one cycle, pending<=0.
  - On frame_end with pending=0: nothing changes and ack stays 0.
  - Simultaneous load and frame_end with pending=1: the old buffer is committed, the new din is captured, pending stays 1, and ack=1. The new data commits at the next frame_end.
  - Simultaneous load and frame_end with pending=0: the data is captured only and commits one frame later.
- Commit latency: data is visible on d0..d3 in the cycle after the first frame_end following the capture edge. Worst case is 4*PRESCALE cycles.
- d0..d3 are the registered active set. They change only on a commit edge.
- Leading-zero suppression, combinational from the active registers; a code is "zero" when code==5'b00000 (dp clear, hex 0):
  - z3 = lz_en && d3 zero
  - z2 = z3 && d2 zero
  - z1 = z2 && d1 zero
  - digit 0 is never suppressed.
  - sup = z[digit].
- Dimming: dim = (cnt >= (PRESCALE/4)*(brightness+1)). brightness=3 never dims.
- blank = sup || dim. It is combinational from registered state and is glitch-free relative to digit.
- brightness and lz_en may change at any time and take effect in the same cycle.
- After reset with lz_en=1: slots 3,2,1 are blank and slot 0 shows code 0.

Test Plan:
- PRESCALE=8, reset released, load idle -> digit steps 0,1,2,3,0 every 8 cycles; d0..d3=0; ack never asserts; blank=0 with lz_en=0 and brightness=3.
- Pulse load with din={5'h01,5'h02,5'h03,5'h04} at cycle 5 (digit 0) -> pending=1. At the edge where cnt=7 and digit=3 (cycle 31): ack=1 for one cycle, d0..d3=01,02,03,04, pending=0.
- Load A at cycle 2, load B at cycle 10 -> only B is committed at cycle 31; a single ack pulse.
- Load A at cycle 20; load B on the frame_end cycle (31) -> A is committed at 31 with ack; B stays pending and commits at cycle 63 with a second ack.
- lz_en=1, active {d3=0,d2=0,d1=5'h07,d0=0} -> blank=1 during digit slots 3 and 2 only. Change d2 to 5'h10 (dp set) -> slot 2 is no longer blanked.
- brightness=0, PRESCALE=8 -> blank=1 for cnt 2..7 of every slot. brightness=1 -> cnt 4..7. Assert reset at cnt=5 with pending=1 -> all registers are zero immediately and no ack occurs.
